// File: rtl/alu_request_arbiter.sv
// Round-robin arbiter sharing one sequential ALU between NUM_REQ requesters.
// Optional ALU watchdog enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_request_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_q,
    input  logic [WIDTH*NUM_REQ-1:0] req_m,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_hi,
    output logic [WIDTH-1:0]         rsp_lo,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     alu_begin,
    output logic [1:0]               alu_op_code,
    output logic [WIDTH-1:0]         alu_inbus,
    output logic                     alu_rst_n,
    input  logic                     alu_push_a,
    input  logic                     alu_push_q,
    input  logic                     alu_end,
    input  logic [WIDTH-1:0]         alu_outbus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
        ISSUE1 = 3'd2,
        ISSUE2 = 3'd3,
        WAIT   = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t             state_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   grant_r;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r, q_r, m_r;
    logic [WIDTH-1:0]   cap_a_r, cap_q_r;

    logic               found_s;
    logic [IDX_W-1:0]   pick_s;
    logic [IDX_W:0]     idx_s;
    logic [1:0]         sel_op_s;
    logic [WIDTH-1:0]   sel_a_s, sel_q_s, sel_m_s;
    logic [WIDTH-1:0]   cap_a_nxt_s, cap_q_nxt_s;
    logic               tmo_hit_s;

    // Round-robin search: scan downwards so the lowest offset from rr_ptr wins.
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        idx_s   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx_s = {1'b0, rr_ptr_r} + (IDX_W + 1)'(i);
            if (idx_s >= (IDX_W + 1)'(NUM_REQ)) begin
                idx_s = idx_s - (IDX_W + 1)'(NUM_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (req_valid[idx_s[IDX_W-1:0]]) begin
                found_s = 1'b1;
                pick_s  = idx_s[IDX_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Operands of the candidate requester.
    always_comb begin
        sel_op_s = req_op[int'(pick_s)*2 +: 2];
        sel_a_s  = req_a[int'(pick_s)*WIDTH +: WIDTH];
        sel_q_s  = req_q[int'(pick_s)*WIDTH +: WIDTH];
        sel_m_s  = req_m[int'(pick_s)*WIDTH +: WIDTH];
    end

    // Capture values including a push landing in the same cycle as END.
    always_comb begin
        cap_a_nxt_s = cap_a_r;
        cap_q_nxt_s = cap_q_r;
        if (state_r == WAIT && alu_push_a) begin
            cap_a_nxt_s = alu_outbus;
        end else begin
            cap_a_nxt_s = cap_a_r;
        end
        if (state_r == WAIT && alu_push_q) begin
            cap_q_nxt_s = alu_outbus;
        end else begin
            cap_q_nxt_s = cap_q_r;
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_r;

    assign tmo_hit_s = (state_r == WAIT) && !alu_end &&
                       (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
    assign alu_rst_n = ~reset & ~tmo_hit_s;

    // Watchdog counts cycles spent in WAIT; held at zero elsewhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_r <= '0;
        end else if (state_r != WAIT) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end
`else
    assign tmo_hit_s = 1'b0;
    assign alu_rst_n = ~reset;
`endif

    // Main FSM with registered ALU-side and requester-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            grant_r     <= '0;
            op_r        <= 2'b00;
            a_r         <= '0;
            q_r         <= '0;
            m_r         <= '0;
            cap_a_r     <= '0;
            cap_q_r     <= '0;
            rsp_valid   <= '0;
            rsp_hi      <= '0;
            rsp_lo      <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            alu_begin   <= 1'b0;
            alu_op_code <= 2'b00;
            alu_inbus   <= '0;
        end else begin
            cap_a_r <= cap_a_nxt_s;
            cap_q_r <= cap_q_nxt_s;
            case (state_r)
                IDLE: begin
                    rsp_valid <= '0;
                    rsp_err   <= 1'b0;
                    if (found_s) begin
                        grant_r     <= pick_s;
                        op_r        <= sel_op_s;
                        a_r         <= sel_a_s;
                        q_r         <= sel_q_s;
                        m_r         <= sel_m_s;
                        cap_a_r     <= '0;
                        cap_q_r     <= '0;
                        busy        <= 1'b1;
                        alu_begin   <= 1'b1;
                        alu_op_code <= sel_op_s;
                        alu_inbus   <= (sel_op_s == OP_MUL) ? sel_q_s : sel_a_s;
                        state_r     <= ISSUE0;
                    end else begin
                        busy      <= 1'b0;
                        alu_begin <= 1'b0;
                        alu_inbus <= '0;
                        state_r   <= IDLE;
                    end
                end
                ISSUE0: begin
                    alu_begin <= 1'b0;
                    alu_inbus <= (op_r == OP_DIV) ? q_r : m_r;
                    state_r   <= ISSUE1;
                end
                ISSUE1: begin
                    if (op_r == OP_DIV) begin
                        alu_inbus <= m_r;
                        state_r   <= ISSUE2;
                    end else begin
                        alu_inbus <= '0;
                        state_r   <= WAIT;
                    end
                end
                ISSUE2: begin
                    alu_inbus <= '0;
                    state_r   <= WAIT;
                end
                WAIT: begin
                    if (alu_end) begin
                        rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_r;
                        rsp_err   <= 1'b0;
                        if (op_r[1]) begin
                            rsp_hi <= cap_a_nxt_s;
                            rsp_lo <= cap_q_nxt_s;
                        end else begin
                            rsp_hi <= '0;
                            rsp_lo <= cap_a_nxt_s;
                        end
                        state_r <= RESP;
                    end else if (tmo_hit_s) begin
                        rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_r;
                        rsp_err   <= 1'b1;
                        rsp_hi    <= '0;
                        rsp_lo    <= '0;
                        state_r   <= RESP;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    rsp_err   <= 1'b0;
                    busy      <= 1'b0;
                    if (grant_r == IDX_W'(NUM_REQ - 1)) begin
                        rr_ptr_r <= '0;
                    end else begin
                        rr_ptr_r <= grant_r + IDX_W'(1);
                    end
                    state_r <= IDLE;
                end
                default: begin
                    rsp_valid <= '0;
                    rsp_err   <= 1'b0;
                    busy      <= 1'b0;
                    alu_begin <= 1'b0;
                    alu_inbus <= '0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_request_arbiter.sv
// Directed bench for alu_request_arbiter with a behavioural sequential-ALU responder.
module tb_alu_request_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = 4'b0;
    logic [7:0]  req_op = 8'h00;
    logic [31:0] req_a = 32'h0, req_q = 32'h0, req_m = 32'h0;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_hi, rsp_lo;
    logic        rsp_err, busy, alu_begin, alu_rst_n;
    logic [1:0]  alu_op_code;
    logic [7:0]  alu_inbus;
    logic        alu_push_a = 1'b0, alu_push_q = 1'b0, alu_end = 1'b0;
    logic [7:0]  alu_outbus = 8'h00;

    int checks = 0;
    int errors = 0;

    alu_request_arbiter #(.NUM_REQ(4), .WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_q(req_q), .req_m(req_m),
        .rsp_valid(rsp_valid), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err),
        .busy(busy), .alu_begin(alu_begin), .alu_op_code(alu_op_code),
        .alu_inbus(alu_inbus), .alu_rst_n(alu_rst_n),
        .alu_push_a(alu_push_a), .alu_push_q(alu_push_q), .alu_end(alu_end),
        .alu_outbus(alu_outbus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         r;
        logic [1:0] op;
        logic [7:0] a, q, m;
        logic [7:0] w0, w1, w2;
        logic [7:0] hi, lo;
        int         lat;
        bit         drop;
    } vec_t;

    vec_t tv[7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [1:0] op, input logic [7:0] a,
                           input logic [7:0] q, input logic [7:0] m);
        req_op[2*r +: 2] = op;
        req_a[8*r +: 8]  = a;
        req_q[8*r +: 8]  = q;
        req_m[8*r +: 8]  = m;
        req_valid[r]     = 1'b1;
    endtask

    // Reference sequential ALU: {hi, lo} from the words received on INBUS.
    function automatic logic [15:0] alu_model(input logic [1:0] op, input logic [7:0] w0,
                                              input logic [7:0] w1, input logic [7:0] w2);
        logic [15:0] dvd;
        logic [15:0] quo, rem;
        case (op)
            2'b00: return {8'h00, 8'(w0 + w1)};
            2'b01: return {8'h00, 8'(w0 - w1)};
            2'b10: return 16'(w0 * w1);
            2'b11: begin
                dvd = {w0, w1};
                quo = (w2 == 8'h00) ? 16'hFFFF : dvd / {8'h00, w2};
                rem = (w2 == 8'h00) ? dvd : dvd % {8'h00, w2};
                return {rem[7:0], quo[7:0]};
            end
            default: return 16'h0000;
        endcase
    endfunction

    // Waits for BEGIN, collects INBUS words, answers after lat idle cycles,
    // and returns sampled in the cycle after END.
    task automatic serve_one(input int lat, input bit drop,
                             output logic [7:0] w0, output logic [7:0] w1, output logic [7:0] w2,
                             output logic [3:0] rv, output logic [7:0] hi, output logic [7:0] lo,
                             output logic e, output bit to);
        logic [1:0]  op;
        logic [15:0] res;
        int n;
        w0 = 8'h00; w1 = 8'h00; w2 = 8'h00; rv = 4'h0; hi = 8'h00; lo = 8'h00; e = 1'b0;
        to = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (alu_begin !== 1'b1 && n < 20);
        if (alu_begin !== 1'b1) begin
            to = 1'b1;
            return;
        end
        w0 = alu_inbus;
        op = alu_op_code;
        if (drop) begin
            req_valid = 4'b0;
            req_a = ~req_a; req_q = ~req_q; req_m = ~req_m;
        end
        tick();
        chk("begin_pulse_width", {31'd0, alu_begin}, 32'd0);
        w1 = alu_inbus;
        if (op == 2'b11) begin
            tick();
            w2 = alu_inbus;
        end
        tick();
        chk("inbus_idle_in_wait", {24'd0, alu_inbus}, 32'd0);
        repeat (lat) tick();
        res = alu_model(op, w0, w1, w2);
        if (op[1] == 1'b0) begin
            alu_push_a = 1'b1; alu_outbus = res[7:0]; alu_end = 1'b1;
            tick();
        end else if (op == 2'b10) begin
            alu_push_a = 1'b1; alu_outbus = res[15:8];
            tick();
            alu_push_a = 1'b0; alu_push_q = 1'b1; alu_outbus = res[7:0]; alu_end = 1'b1;
            tick();
        end else begin
            alu_push_q = 1'b1; alu_outbus = res[7:0];
            tick();
            alu_push_q = 1'b0; alu_push_a = 1'b1; alu_outbus = res[15:8]; alu_end = 1'b1;
            tick();
        end
        alu_push_a = 1'b0; alu_push_q = 1'b0; alu_end = 1'b0; alu_outbus = 8'h00;
        rv = rsp_valid; hi = rsp_hi; lo = rsp_lo; e = rsp_err;
        chk("busy_in_resp", {31'd0, busy}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [7:0] w0, w1, w2, hi, lo;
        logic [3:0] rv;
        logic       e;
        bit         to;

        tv[0] = '{0, 2'b00, 8'h12, 8'h00, 8'h05, 8'h12, 8'h05, 8'h00, 8'h00, 8'h17, 0, 1'b0};
        tv[1] = '{2, 2'b10, 8'h55, 8'h07, 8'h06, 8'h07, 8'h06, 8'h00, 8'h00, 8'h2A, 2, 1'b0};
        tv[2] = '{1, 2'b11, 8'h00, 8'h64, 8'h07, 8'h00, 8'h64, 8'h07, 8'h02, 8'h0E, 3, 1'b0};
        tv[3] = '{3, 2'b01, 8'h30, 8'h99, 8'h45, 8'h30, 8'h45, 8'h00, 8'h00, 8'hEB, 1, 1'b0};
        tv[4] = '{1, 2'b10, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFE, 8'h01, 5, 1'b0};
        tv[5] = '{0, 2'b11, 8'h01, 8'h00, 8'h10, 8'h01, 8'h00, 8'h10, 8'h00, 8'h10, 0, 1'b0};
        tv[6] = '{3, 2'b00, 8'hFF, 8'h3C, 8'h01, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 4, 1'b1};

        // Reset values.
        tick(); tick();
        chk("reset_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_hi", {24'd0, rsp_hi}, 32'd0);
        chk("reset_rsp_lo", {24'd0, rsp_lo}, 32'd0);
        chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_begin", {31'd0, alu_begin}, 32'd0);
        chk("reset_op_code", {30'd0, alu_op_code}, 32'd0);
        chk("reset_inbus", {24'd0, alu_inbus}, 32'd0);
        chk("reset_alu_rst_n", {31'd0, alu_rst_n}, 32'd0);
        reset = 1'b0;
        tick();
        chk("alu_rst_n_released", {31'd0, alu_rst_n}, 32'd1);

        // Strobes while idle are ignored.
        alu_push_a = 1'b1; alu_end = 1'b1; alu_outbus = 8'hAA;
        tick();
        alu_push_a = 1'b0; alu_end = 1'b0; alu_outbus = 8'h00;
        tick();
        chk("idle_end_ignored_valid", {28'd0, rsp_valid}, 32'd0);
        chk("idle_end_ignored_busy", {31'd0, busy}, 32'd0);

        // Fairness: all four held valid.
        for (int j = 0; j < 4; j++) set_req(j, 2'b00, 8'h20 + 8'(j), 8'h00, 8'h03);
        for (int k = 0; k < 5; k++) begin
            serve_one(k, 1'b0, w0, w1, w2, rv, hi, lo, e, to);
            chk("fair_begin_seen", {31'd0, to}, 32'd0);
            chk("fair_grant", {28'd0, rv}, {28'd0, 4'b0001 << (k % 4)});
            chk("fair_lo", {24'd0, lo}, {24'd0, 8'h23 + 8'(k % 4)});
        end
        req_valid = 4'b0;
        tick();

        // Table-driven single-requester operations.
        for (int i = 0; i < 7; i++) begin
            set_req(tv[i].r, tv[i].op, tv[i].a, tv[i].q, tv[i].m);
            serve_one(tv[i].lat, tv[i].drop, w0, w1, w2, rv, hi, lo, e, to);
            chk("vec_begin_seen", {31'd0, to}, 32'd0);
            chk("vec_word0", {24'd0, w0}, {24'd0, tv[i].w0});
            chk("vec_word1", {24'd0, w1}, {24'd0, tv[i].w1});
            if (tv[i].op == 2'b11) chk("vec_word2", {24'd0, w2}, {24'd0, tv[i].w2});
            chk("vec_rsp_valid", {28'd0, rv}, {28'd0, 4'b0001 << tv[i].r});
            chk("vec_rsp_hi", {24'd0, hi}, {24'd0, tv[i].hi});
            chk("vec_rsp_lo", {24'd0, lo}, {24'd0, tv[i].lo});
            chk("vec_rsp_err", {31'd0, e}, 32'd0);
            req_valid = 4'b0;
            tick();
            chk("vec_valid_one_cycle", {28'd0, rsp_valid}, 32'd0);
            chk("vec_busy_cleared", {31'd0, busy}, 32'd0);
        end

        // Reset in the middle of WAIT during a mul.
        set_req(2, 2'b10, 8'h00, 8'h07, 8'h06);
        tick(); tick(); tick(); tick(); tick();
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("reset_mid_alu_rst_n", {31'd0, alu_rst_n}, 32'd0);
        tick();
        chk("reset_mid_valid", {28'd0, rsp_valid}, 32'd0);
        chk("reset_mid_busy", {31'd0, busy}, 32'd0);
        chk("reset_mid_inbus", {24'd0, alu_inbus}, 32'd0);
        chk("reset_mid_op_code", {30'd0, alu_op_code}, 32'd0);
        reset = 1'b0;
        serve_one(1, 1'b0, w0, w1, w2, rv, hi, lo, e, to);
        chk("regrant_begin_seen", {31'd0, to}, 32'd0);
        chk("regrant_valid", {28'd0, rv}, 32'h4);
        chk("regrant_hi", {24'd0, hi}, 32'h00);
        chk("regrant_lo", {24'd0, lo}, 32'h2A);
        req_valid = 4'b0;
        tick();

`ifdef ALU_ARB_TIMEOUT_EN
        // Watchdog: the ALU never raises END.
        set_req(0, 2'b10, 8'h00, 8'h03, 8'h04);
        tick();
        chk("tmo_begin", {31'd0, alu_begin}, 32'd1);
        tick(); tick();
        for (int k = 1; k <= 16; k++) begin
            chk("tmo_alu_rst_n", {31'd0, alu_rst_n}, (k == 16) ? 32'd0 : 32'd1);
            if (k < 16) tick();
        end
        tick();
        chk("tmo_rsp_valid", {28'd0, rsp_valid}, 32'h1);
        chk("tmo_rsp_err", {31'd0, rsp_err}, 32'd1);
        chk("tmo_rsp_hi", {24'd0, rsp_hi}, 32'd0);
        chk("tmo_rsp_lo", {24'd0, rsp_lo}, 32'd0);
        chk("tmo_alu_rst_n_back", {31'd0, alu_rst_n}, 32'd1);
        req_valid = 4'b0;
        tick();
        chk("tmo_err_cleared", {31'd0, rsp_err}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_request_arbiter.md
# alu_request_arbiter

Round-robin scheduler sharing one sequential ALU control unit and datapath (add/sub, Radix-4 mul, SRT-2 div) between `NUM_REQ` requesters. Latches the winning request's opcode and operands, issues the BEGIN pulse, serialises operands onto the ALU INBUS in the order the ALU loads them, and captures OUTBUS words on the ALU push strobes. Returns the result to the granted requester on END. Sits between the core's requester ports and the ALU top level.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: INBUS/OUTBUS word width.
- `TIMEOUT_CYCLES`, 64: watchdog limit, used only with `ALU_ARB_TIMEOUT_EN`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester request; held until that requester's `rsp_valid`.
- `req_op`  in  2*NUM_REQ  opcode per requester: 00 add, 01 sub, 10 mul, 11 div.
- `req_a`, `req_q`, `req_m`  in  WIDTH*NUM_REQ each  operands A (div: dividend high), Q (mul multiplier, div: dividend low), M.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle response pulse.
- `rsp_hi`, `rsp_lo`  out  WIDTH each  result words, valid with `rsp_valid`.
- `rsp_err`  out  1  valid with `rsp_valid`; 1 = aborted operation.
- `busy`  out  1  high from grant through the response cycle.
- `alu_begin`  out  1  BEGIN to the ALU.
- `alu_op_code`  out  2  opcode to the ALU, held stable from ISSUE0 through WAIT.
- `alu_inbus`  out  WIDTH  INBUS drive.
- `alu_rst_n`  out  1  active-low ALU reset.
- `alu_push_a`, `alu_push_q`, `alu_end`  in  1 each  ALU strobes.
- `alu_outbus`  in  WIDTH  OUTBUS, valid in a push cycle.

## Operation
- FSM states: IDLE, ISSUE0, ISSUE1, ISSUE2, WAIT, RESP.
- IDLE: if any `req_valid`, grant the first set bit at or after `rr_ptr`, wrapping from NUM_REQ-1 to 0. Latch grantee index, opcode, A/Q/M, and go to ISSUE0. With no request, stay in IDLE.
- ISSUE0: `alu_begin`=1, `alu_inbus`=word0. Always go to ISSUE1.
- ISSUE1: `alu_inbus`=word1. Next state is ISSUE2 for div, WAIT otherwise.
- ISSUE2 (div only): `alu_inbus`=word2, then WAIT.
- Word order:
  - add/sub: A, M.
  - mul: Q, M.
  - div: A, Q, M.
- WAIT:
  - `alu_push_a` loads `alu_outbus` into the A capture register; `alu_push_q` loads it into the Q capture register.
  - `alu_end` moves to RESP. A push in the same cycle as `alu_end` is captured.
- Result mapping:
  - add/sub: `rsp_lo`=A, `rsp_hi`=0.
  - mul: `rsp_hi`=A, `rsp_lo`=Q.
  - div: `rsp_hi`=A (remainder), `rsp_lo`=Q (quotient).
- RESP: pulse `rsp_valid[grant]`, set `rr_ptr`=grant+1 mod NUM_REQ, return to IDLE. Earliest next grant is the cycle after RESP.
- Outside ISSUE states, `alu_inbus`=0 and `alu_begin`=0.
- Pushes or END seen outside WAIT are ignored.
- Requester dropping `req_valid` after grant: the operation completes and `rsp_valid` still pulses.
- Requester operand changes after grant are ignored.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, capture registers 0, `rsp_valid`=0, `rsp_hi`/`rsp_lo`=0, `rsp_err`=0, `busy`=0, `alu_begin`=0, `alu_op_code`=00, `alu_inbus`=0.
- `alu_rst_n` = ~`reset` (combinational), so the ALU is held in reset together with the arbiter.
- Reset mid-operation: abort immediately. No response is issued for the in-flight request; it re-arbitrates after reset.
- Request to `alu_begin`: 1 cycle (grant registered in IDLE, ISSUE0 the next cycle).
- ALU latency is not fixed. The arbiter waits on `alu_end` only.
- `rsp_valid` is asserted exactly one cycle after the `alu_end` cycle.

## Configuration
- `ALU_ARB_TIMEOUT_EN` defined:
  - A counter clears on entering WAIT and increments each cycle in WAIT.
  - If it reaches TIMEOUT_CYCLES without `alu_end`, drive `alu_rst_n`=0 for one cycle and go to RESP with `rsp_err`=1 and `rsp_hi`/`rsp_lo`=0.
  - `alu_end` and the timeout in the same cycle: `alu_end` wins and there is no error.
- `ALU_ARB_TIMEOUT_EN` undefined: no counter is built, WAIT is unbounded, and `rsp_err` is tied to 0.

## Test plan
- Single add: req0 op=00, A=0x12, M=0x05 -> `alu_begin` with INBUS 0x12, next cycle 0x05; `rsp_valid`=0001, `rsp_lo`=0x17, `rsp_hi`=0.
- Mul: req2 op=10, Q=0x07, M=0x06 -> INBUS order 0x07, 0x06; `rsp_hi`=0x00, `rsp_lo`=0x2A.
- Div: req1 op=11, A=0x00, Q=0x64, M=0x07 -> INBUS order 0x00, 0x64, 0x07 on three consecutive cycles; `rsp_lo`=0x0E, `rsp_hi`=0x02.
- Fairness: all four requesters held valid -> grants in order 0, 1, 2, 3, 0; no requester is served twice before the others are served.
- Reset mid-WAIT: assert `reset` for 1 cycle during a mul -> no `rsp_valid`, all outputs at reset values, the held request is re-granted and completes correctly.
- Timeout (macro on, TIMEOUT_CYCLES=16): model never asserts `alu_end` -> `alu_rst_n` low for 1 cycle at WAIT cycle 16; `rsp_valid` with `rsp_err`=1 the next cycle.
